// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the hex_scan digit feeder and its BCD converter.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int          NDIG      = 4;
    localparam int          DIGW      = 4;
    localparam logic [15:0] BCD_MAX   = 16'd9999;
    localparam int          BCD_ITERS = 16;

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the next shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < NDIG; i++) begin
            if (b[i*DIGW +: DIGW] >= 4'd5)
                r[i*DIGW +: DIGW] = b[i*DIGW +: DIGW] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary (<= 9999) to four BCD digits.
// The start cycle performs the first shift, so done is raised 15 cycles after start.
module bin2bcd_seq
    import hex_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [15:0] bcd,
    output logic        done
);

    logic [15:0] sh;
    logic [3:0]  cnt;
    logic        running;

    assign done = running && (cnt == 4'd0);

    // One shift per cycle; the BCD register is already zero-adjusted on the first shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd     <= '0;
            sh      <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            bcd     <= {15'd0, bin[15]};
            sh      <= {bin[14:0], 1'b0};
            cnt     <= 4'(BCD_ITERS - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt != 4'd0) begin
                {bcd, sh} <= {dabble_adjust(bcd), sh} << 1;
                cnt       <= cnt - 4'd1;
            end else begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hex_scan.sv
// Feeds a 4-digit 7-segment decoder one digit write at a time from a 16-bit word.
// Define HEX_SCAN_BCD_EN to build the decimal (BCD) display path and the ovf flag.
module hex_scan
    import hex_scan_pkg::*;
#(
    parameter int PACE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_dec,
    output logic        en,
    output logic [3:0]  val,
    output logic [1:0]  dig,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam int           CW     = $clog2(PACE) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(PACE - 1);

    state_t        state, state_next;
    logic          transfer, dec_sel, wr, last_wr;
    logic [15:0]   data_q, wr_word;
    logic [1:0]    wr_idx, next_idx;
    logic [CW-1:0] pace_cnt;

    assign transfer = in_valid && (state == IDLE) && !rst;
    assign last_wr  = en && (dig == 2'(NDIG - 1));

`ifdef HEX_SCAN_BCD_EN
    logic        conv_done;
    logic [15:0] bcd;

    assign dec_sel = in_dec;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (transfer && in_dec),
        .bin   ((in_data > BCD_MAX) ? BCD_MAX : in_data),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Overflow reflects only the most recently accepted word.
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (transfer)
            ovf <= in_dec && (in_data > BCD_MAX);
    end
`else
    logic unused_dec;
    assign unused_dec = in_dec;
    assign dec_sel    = 1'b0;
    assign ovf        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // EMIT is left only once the digit-3 write is visible, so in_ready follows it by a cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (transfer) state_next = dec_sel ? CONV : EMIT;
`ifdef HEX_SCAN_BCD_EN
            CONV: if (conv_done) state_next = EMIT;
`endif
            EMIT: if (last_wr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Digit 0 is written straight from the incoming word (hex) or the finished BCD result.
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        wr       = 1'b0;
        wr_word  = data_q;
        wr_idx   = next_idx;
        case (state)
            IDLE: begin
                if (transfer && !dec_sel) begin
                    wr      = 1'b1;
                    wr_word = in_data;
                    wr_idx  = 2'd0;
                end
            end
`ifdef HEX_SCAN_BCD_EN
            CONV: begin
                if (conv_done) begin
                    wr      = 1'b1;
                    wr_word = bcd;
                    wr_idx  = 2'd0;
                end
            end
`endif
            EMIT: begin
                if (!last_wr && (pace_cnt == '0))
                    wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            val      <= '0;
            dig      <= '0;
            done     <= 1'b0;
            data_q   <= '0;
            next_idx <= '0;
            pace_cnt <= '0;
        end else begin
            en   <= wr;
            done <= wr && (wr_idx == 2'(NDIG - 1));
            if (wr) begin
                val      <= wr_word[{wr_idx, 2'b00} +: DIGW];
                dig      <= wr_idx;
                next_idx <= wr_idx + 2'd1;
                pace_cnt <= RELOAD;
            end else if (pace_cnt != '0) begin
                pace_cnt <= pace_cnt - 1'b1;
            end
            if (transfer)
                data_q <= in_data;
`ifdef HEX_SCAN_BCD_EN
            else if ((state == CONV) && conv_done)
                data_q <= bcd;
`endif
        end
    end

endmodule

// File: tb/tb_hex_scan.sv
// Self-checking bench for hex_scan: directed words followed by random traffic, all checked
// every cycle against a schedule-based model of when each digit write must appear.
module tb_hex_scan;

    localparam int PACE       = 2;
    localparam int NC         = 2000;
    localparam int RAND_START = 90;
`ifdef HEX_SCAN_BCD_EN
    localparam bit BCD_ON = 1'b1;
`else
    localparam bit BCD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_dec = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, en, busy, done, ovf;
    logic [3:0]  val;
    logic [1:0]  dig;

    hex_scan #(.PACE(PACE)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dec   (in_dec),
        .en       (en),
        .val      (val),
        .dig      (dig),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected write schedule, indexed by cycle.
    bit w_en   [NC+64];
    bit w_done [NC+64];
    int w_val  [NC+64];
    int w_dig  [NC+64];

    // DUT observations kept for the literal spot checks.
    logic [31:0] d_code  [NC];
    logic        d_ovf   [NC];
    logic        d_ready [NC];
    logic        d_done  [NC];

    int free_at  = 0;
    bit rst_prev = 1'b1;
    int last_val = 0;
    int last_dig = 0;
    bit ovf_exp  = 1'b0;
    int pend_c   = -1;
    bit pend_v   = 1'b0;

    task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Word accepted in cycle t: digit k appears at T0 + k*PACE.
    task automatic schedule(input int t, input logic [15:0] word, input bit dec);
        int v, t0, c;
        int d [4];
        v = int'(word);
        if (dec && v > 9999) v = 9999;
        for (int k = 0; k < 4; k++) begin
            if (dec) begin
                d[k] = v % 10;
                v    = v / 10;
            end else begin
                d[k] = (int'(word) >> (4 * k)) & 15;
            end
        end
        t0 = t + (dec ? 17 : 1);
        for (int k = 0; k < 4; k++) begin
            c         = t0 + k * PACE;
            w_en[c]   = 1'b1;
            w_dig[c]  = k;
            w_val[c]  = d[k];
            w_done[c] = (k == 3);
        end
        free_at = t0 + 3 * PACE + 1;
        pend_c  = t + 1;
        pend_v  = dec && (word > 16'd9999);
    endtask

    task automatic applyStimulus(input int c);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_dec   = 1'($urandom);
        if (c < 3) rst = 1'b1;
        if (c == 3) begin in_valid = 1'b1; in_data = 16'hBEEF; in_dec = 1'b0; end
        if (c >= 4 && c <= 10) in_valid = 1'b1;
        if (c == 12) begin in_valid = 1'b1; in_data = 16'h5678; in_dec = 1'b0; end
        if (c == 16) rst = 1'b1;
        if (c == 18) begin in_valid = 1'b1; in_data = 16'h00A0; in_dec = 1'b0; end
        if (c == 26) begin in_valid = 1'b1; in_data = 16'd1234;  in_dec = 1'b1; end
        if (c == 50) begin in_valid = 1'b1; in_data = 16'd12345; in_dec = 1'b1; end
        if (c == 74) begin in_valid = 1'b1; in_data = 16'h0001;  in_dec = 1'b0; end
        if (c >= RAND_START) begin
            rst      = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                in_data = 16'($urandom_range(9990, 10010));
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            if (rst_prev) begin
                last_val = 0;
                last_dig = 0;
                ovf_exp  = 1'b0;
            end else if (pend_c == c) begin
                ovf_exp = pend_v;
            end
            if (w_en[c]) begin
                last_val = w_val[c];
                last_dig = w_dig[c];
            end

            d_code[c]  = 32'({en, 2'b00, dig, val});
            d_ovf[c]   = ovf;
            d_ready[c] = in_ready;
            d_done[c]  = done;

            checkOutput("en",       c, 32'(en),       32'(w_en[c]));
            checkOutput("val",      c, 32'(val),      32'(last_val));
            checkOutput("dig",      c, 32'(dig),      32'(last_dig));
            checkOutput("done",     c, 32'(done),     32'(w_done[c]));
            checkOutput("busy",     c, 32'(busy),     32'(c < free_at));
            checkOutput("in_ready", c, 32'(in_ready), 32'(c >= free_at));
            checkOutput("ovf",      c, 32'(ovf),      32'(ovf_exp));

            applyStimulus(c);
            if (rst) begin
                for (int j = c + 1; j <= c + 40; j++) begin
                    w_en[j]   = 1'b0;
                    w_done[j] = 1'b0;
                end
                free_at = c + 1;
                pend_c  = -1;
            end else if (in_valid && c >= free_at) begin
                schedule(c, in_data, BCD_ON && in_dec);
            end
            rst_prev = rst;
        end

        checkOutput("lit_beef_d0",   4,  d_code[4],  32'h10F);
        checkOutput("lit_beef_d1",   6,  d_code[6],  32'h11E);
        checkOutput("lit_beef_d2",   8,  d_code[8],  32'h12E);
        checkOutput("lit_beef_d3",   10, d_code[10], 32'h13B);
        checkOutput("lit_beef_done", 10, 32'(d_done[10]),  32'd1);
        checkOutput("lit_busy_rdy",  10, 32'(d_ready[10]), 32'd0);
        checkOutput("lit_free_rdy",  11, 32'(d_ready[11]), 32'd1);
        checkOutput("lit_5678_d1",   15, d_code[15], 32'h117);
        checkOutput("lit_rst_clear", 17, d_code[17], 32'h000);
        checkOutput("lit_rst_rdy",   17, 32'(d_ready[17]), 32'd1);
        checkOutput("lit_00a0_d1",   21, d_code[21], 32'h11A);
        checkOutput("lit_00a0_d3",   25, d_code[25], 32'h130);
`ifdef HEX_SCAN_BCD_EN
        checkOutput("lit_dec_d0",    43, d_code[43], 32'h104);
        checkOutput("lit_dec_d1",    45, d_code[45], 32'h113);
        checkOutput("lit_dec_d3",    49, d_code[49], 32'h131);
        checkOutput("lit_dec_ovf0",  30, 32'(d_ovf[30]), 32'd0);
        checkOutput("lit_clamp_d0",  67, d_code[67], 32'h109);
        checkOutput("lit_clamp_d3",  73, d_code[73], 32'h139);
        checkOutput("lit_clamp_ovf", 74, 32'(d_ovf[74]), 32'd1);
        checkOutput("lit_hex1_d0",   75, d_code[75], 32'h101);
        checkOutput("lit_hex1_ovf",  76, 32'(d_ovf[76]), 32'd0);
`else
        checkOutput("lit_nodec_d0",  27, d_code[27], 32'h102);
        checkOutput("lit_nodec_d1",  29, d_code[29], 32'h11D);
        checkOutput("lit_nodec_d3",  33, d_code[33], 32'h130);
        checkOutput("lit_nodec_big", 51, d_code[51], 32'h109);
        checkOutput("lit_nodec_ovf", 52, 32'(d_ovf[52]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
